// File: rtl/opcode_selector_if.sv
// Button inputs and opcode/status outputs of the opcode selector, bundled for the calculator top.
interface opcode_selector_if;
    logic       btn_next_i;
    logic       btn_prev_i;
    logic [3:0] opcode_o;
    logic       step_pulse_o;
    logic       next_level_o;
    logic       prev_level_o;

    modport master (
        output btn_next_i,
        output btn_prev_i,
        input  opcode_o,
        input  step_pulse_o,
        input  next_level_o,
        input  prev_level_o
    );

    modport slave (
        input  btn_next_i,
        input  btn_prev_i,
        output opcode_o,
        output step_pulse_o,
        output next_level_o,
        output prev_level_o
    );
endinterface

// File: rtl/opcode_selector.sv
// Push-button opcode stepper: per-button synchronizer, debouncer and press detector,
// feeding a wrapping opcode-index FSM whose registered opcode drives the ALU.
module opcode_selector_button #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_btn,
    output logic level,
    output logic press
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          pressed_raw;
    logic          sync_meta;
    logic          sync_q;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] count;

    assign pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~raw_btn : raw_btn;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= pressed_raw;
            sync_q    <= sync_meta;
        end
    end

    // A new level is accepted only after it has persisted for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync_q == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= sync_q;
            count  <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign level = stable;
    assign press = stable & ~stable_d;
endmodule

module opcode_selector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    opcode_selector_if.slave bus
);
    typedef enum logic [3:0] {
        IDX_0 = 4'd0,
        IDX_1 = 4'd1,
        IDX_2 = 4'd2,
        IDX_3 = 4'd3,
        IDX_4 = 4'd4,
        IDX_5 = 4'd5,
        IDX_6 = 4'd6,
        IDX_7 = 4'd7,
        IDX_8 = 4'd8,
        IDX_9 = 4'd9
    } idx_t;

    logic       next_level;
    logic       prev_level;
    logic       next_press;
    logic       prev_press;
    idx_t       idx_q;
    idx_t       idx_d;
    idx_t       idx_up;
    idx_t       idx_dn;
    logic       idx_bad;
    logic [3:0] opcode_q;
    logic [3:0] opcode_d;
    logic       pulse_q;
    logic       pulse_d;

    function automatic logic [3:0] opcode_of(input idx_t idx);
        logic [3:0] op;
        op = 4'd6;
        case (idx)
            IDX_0:   op = 4'd0;
            IDX_1:   op = 4'd1;
            IDX_2:   op = 4'd2;
            IDX_3:   op = 4'd3;
            IDX_4:   op = 4'd4;
            IDX_5:   op = 4'd5;
            IDX_6:   op = 4'd6;
            IDX_7:   op = 4'd7;
            IDX_8:   op = 4'd9;
            IDX_9:   op = 4'd14;
            default: op = 4'd6;
        endcase
        return op;
    endfunction

    opcode_selector_button #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_next_btn (
        .clk     (clk_i),
        .rst     (rst_i),
        .raw_btn (bus.btn_next_i),
        .level   (next_level),
        .press   (next_press)
    );

    opcode_selector_button #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_prev_btn (
        .clk     (clk_i),
        .rst     (rst_i),
        .raw_btn (bus.btn_prev_i),
        .level   (prev_level),
        .press   (prev_press)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q    <= IDX_6;
            opcode_q <= 4'd6;
            pulse_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            pulse_q  <= pulse_d;
        end
    end

    // Encodings 10..15 cannot be reached; if one ever appears, recover to the reset index.
    always_comb begin
        idx_up  = IDX_6;
        idx_dn  = IDX_6;
        idx_bad = 1'b0;
        case (idx_q)
            IDX_0:   begin idx_up = IDX_1; idx_dn = IDX_9; end
            IDX_1:   begin idx_up = IDX_2; idx_dn = IDX_0; end
            IDX_2:   begin idx_up = IDX_3; idx_dn = IDX_1; end
            IDX_3:   begin idx_up = IDX_4; idx_dn = IDX_2; end
            IDX_4:   begin idx_up = IDX_5; idx_dn = IDX_3; end
            IDX_5:   begin idx_up = IDX_6; idx_dn = IDX_4; end
            IDX_6:   begin idx_up = IDX_7; idx_dn = IDX_5; end
            IDX_7:   begin idx_up = IDX_8; idx_dn = IDX_6; end
            IDX_8:   begin idx_up = IDX_9; idx_dn = IDX_7; end
            IDX_9:   begin idx_up = IDX_0; idx_dn = IDX_8; end
            default: idx_bad = 1'b1;
        endcase

        idx_d = idx_q;
        if (idx_bad) begin
            idx_d = IDX_6;
        end else if (next_press && !prev_press) begin
            idx_d = idx_up;
        end else if (prev_press && !next_press) begin
            idx_d = idx_dn;
        end

        opcode_d = opcode_of(idx_d);
        pulse_d  = (opcode_d != opcode_q);
    end

    assign bus.opcode_o     = opcode_q;
    assign bus.step_pulse_o = pulse_q;
    assign bus.next_level_o = next_level;
    assign bus.prev_level_o = prev_level;
endmodule

// File: tb/tb_opcode_selector.sv
// Self-checking bench for opcode_selector: directed scenarios with literal expectations,
// then random button activity, all compared every cycle against a sample-history model.
module tb_opcode_selector;
    localparam int DC = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    opcode_selector_if bus ();

    opcode_selector #(
        .DEBOUNCE_CYCLES (DC),
        .BTN_ACTIVE_LOW  (0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a button level is accepted once the last DC synchronized samples
    // (raw sampled two edges earlier) all disagree with it; a rise acts one edge later.
    int   op_table [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 14};
    bit   hist [2][DC+1];
    bit   m_stable [2];
    bit   m_rose [2];
    bit   raw_s [2];
    bit   all_diff;
    int   m_idx;
    int   new_idx;
    int   m_op;
    bit   m_pulse;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j <= DC; j++) hist[b][j] = 1'b0;
                m_stable[b] = 1'b0;
                m_rose[b]   = 1'b0;
            end
            m_idx       = 6;
            m_op        = 6;
            m_pulse     = 1'b0;
            model_valid = 1'b1;
        end else begin
            new_idx = m_idx;
            if (m_rose[0] && !m_rose[1]) new_idx = (m_idx + 1) % 10;
            else if (m_rose[1] && !m_rose[0]) new_idx = (m_idx + 9) % 10;
            m_pulse = (op_table[new_idx] != m_op);
            m_op    = op_table[new_idx];
            m_idx   = new_idx;

            raw_s[0] = bus.btn_next_i;
            raw_s[1] = bus.btn_prev_i;
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DC; j++) begin
                    if (hist[b][j] == m_stable[b]) all_diff = 1'b0;
                end
                m_rose[b] = 1'b0;
                if (all_diff) begin
                    m_stable[b] = ~m_stable[b];
                    m_rose[b]   = m_stable[b];
                end
                for (int j = DC; j >= 1; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = raw_s[b];
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_opcode", int'(bus.opcode_o), m_op);
            checkOutput("model_pulse", int'(bus.step_pulse_o), int'(m_pulse));
            checkOutput("model_next_level", int'(bus.next_level_o), int'(m_stable[0]));
            checkOutput("model_prev_level", int'(bus.prev_level_o), int'(m_stable[1]));
        end
    end

    task automatic applyStimulus(input bit nxt, input bit prv, input int cycles);
        bus.btn_next_i = nxt;
        bus.btn_prev_i = prv;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressNext();
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic pressPrev();
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic holdReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        checkOutput("reset_opcode", int'(bus.opcode_o), 6);
        checkOutput("reset_pulse", int'(bus.step_pulse_o), 0);
        rst = 1'b0;
    endtask

    int expected_seq [4] = '{9, 14, 0, 1};

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.btn_next_i = 1'b0;
        bus.btn_prev_i = 1'b0;
        @(negedge clk);
        holdReset(3);
        checkOutput("reset_next_level", int'(bus.next_level_o), 0);
        checkOutput("reset_prev_level", int'(bus.prev_level_o), 0);

        // Next held from E1: level at E6, opcode 7 and pulse at E7, pulse gone at E8.
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("e5_next_level", int'(bus.next_level_o), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("e6_next_level", int'(bus.next_level_o), 1);
        checkOutput("e6_opcode", int'(bus.opcode_o), 6);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("e7_opcode", int'(bus.opcode_o), 7);
        checkOutput("e7_pulse", int'(bus.step_pulse_o), 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("e8_pulse", int'(bus.step_pulse_o), 0);
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("after_release_opcode", int'(bus.opcode_o), 7);

        for (int i = 0; i < 4; i++) begin
            pressNext();
            checkOutput("next_seq_opcode", int'(bus.opcode_o), expected_seq[i]);
        end

        holdReset(2);
        pressPrev();
        checkOutput("prev_from_reset", int'(bus.opcode_o), 5);
        for (int i = 0; i < 5; i++) pressPrev();
        checkOutput("prev_to_zero", int'(bus.opcode_o), 0);
        pressPrev();
        checkOutput("prev_wrap", int'(bus.opcode_o), 14);

        holdReset(2);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 3);
            applyStimulus(1'b0, 1'b0, 3);
            checkOutput("glitch_level", int'(bus.next_level_o), 0);
        end
        checkOutput("glitch_opcode", int'(bus.opcode_o), 6);

        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("both_opcode", int'(bus.opcode_o), 6);
        checkOutput("both_next_level", int'(bus.next_level_o), 1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("both_release_opcode", int'(bus.opcode_o), 6);

        // Reset lands mid-debounce while next stays held; step follows the full latency.
        applyStimulus(1'b1, 1'b0, 2);
        holdReset(2);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("rst_mid_e6_opcode", int'(bus.opcode_o), 6);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("rst_mid_e7_opcode", int'(bus.opcode_o), 7);
        applyStimulus(1'b0, 1'b0, 10);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                holdReset($urandom_range(1, 3));
            end
            applyStimulus(1'(($urandom_range(0, 3) == 0) ? 1 : 0),
                          1'(($urandom_range(0, 4) == 0) ? 1 : 0),
                          $urandom_range(1, 12));
        end
        applyStimulus(1'b0, 1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
